// File: rtl/param_mem_pkg.sv
// Shared types and helpers for the parametrised ROM/RAM memory controller.
package param_mem_pkg;

  // Controller FSM: RUN serves requests, CLEAR zeroes the RAM region.
  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  // Boot-table image word i: (i+1)*0x11, truncated to data_w bits.
  function automatic logic [63:0] rom_word(input int i, input int data_w);
    logic [63:0] v;
    v = 64'(i + 1) * 64'h11;
    if (data_w < 64) begin
      v = v & ((64'd1 << data_w) - 64'd1);
    end
    return v;
  endfunction

endpackage

// File: rtl/param_mem_array.sv
// Single-port synchronous word array with registered read.
// Words below ROM_WORDS are the constant boot image and are served from
// rom_word(); the storage behind them is never written by the controller.
// RAM words power up as zero; reset is deliberately not connected so that
// contents survive a reset.
module param_mem_array
  import param_mem_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 4,
  parameter int DEPTH     = 16,
  parameter int ROM_WORDS = 8
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int              AW1     = ADDR_W + 1;
  localparam logic [AW1-1:0]  ROM_LIM = AW1'(ROM_WORDS);

  logic [DATA_W-1:0] ram_q [DEPTH] = '{default: '0};
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] rdata_d;
  logic              in_rom;

  assign in_rom = ({1'b0, addr} < ROM_LIM);

  // Read port: capture the addressed word on a read, otherwise hold.
  always_comb begin
    rdata_d = rdata_q;
    if (en && !we) begin
      if (in_rom) begin
        rdata_d = DATA_W'(rom_word(int'(addr), DATA_W));
      end else begin
        rdata_d = ram_q[addr];
      end
    end
  end

  // Storage and read register update.
  always_ff @(posedge clk) begin
    if (en && we) begin
      ram_q[addr] <= wdata;
    end
    rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/param_mem_ctrl.sv
// Parametrised ROM/RAM memory controller.
// Lower ROM_WORDS words are a write-protected boot image, the rest is RAM.
// A clear sequencer zeroes the RAM region one word per cycle.
//
// Handshake: a request transfers on a rising clk edge where req_valid and
// req_ready are both 1; req_we/req_addr/req_wdata/mode are sampled on that
// edge only. req_ready depends only on controller state, never on req_valid.
// The response (rsp_valid/rsp_rdata/rsp_err) is a single-cycle strobe that
// appears after the edge following acceptance; there is no response
// back-pressure, so back-to-back requests yield back-to-back responses.
module param_mem_ctrl
  import param_mem_pkg::*;
#(
  parameter int DATA_W         = 8,
  parameter int ADDR_W         = 4,
  parameter int DEPTH          = 2 ** ADDR_W,
  parameter int ROM_WORDS      = 8,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mode,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  input  logic              clr_req,
  output logic              busy
);

  localparam int             CNT_W     = ADDR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_LIM = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ROM_LIM   = CNT_W'(ROM_WORDS);
  localparam logic [CNT_W-1:0] LAST_ADDR = CNT_W'(DEPTH - 1);
  localparam logic           HAS_RAM   = (ROM_WORDS < DEPTH);
  localparam logic           CLR_RST   = (CLEAR_ON_RESET != 0);
  localparam state_e         RST_STATE = CLR_RST ? ST_CLEAR : ST_RUN;

  // FSM and clear sequencer
  state_e           state_q, state_d;
  logic [CNT_W-1:0] clr_addr_q, clr_addr_d;
  logic             busy_q, busy_d;
  logic             ready_q, ready_d;

  // Accepted-request stage (array read in flight) and response register
  logic              pend_valid_q, pend_valid_d;
  logic              pend_err_q, pend_err_d;
  logic              pend_rd_q, pend_rd_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

  // Request decode
  logic [CNT_W-1:0] addr_ext;
  logic             addr_in_range;
  logic             addr_in_ram;
  logic             accept;
  logic             wr_ok;
  logic             clr_last;

  // Array port
  logic              arr_en;
  logic              arr_we;
  logic [ADDR_W-1:0] arr_addr;
  logic [DATA_W-1:0] arr_wdata;
  logic [DATA_W-1:0] arr_rdata;

  assign addr_ext      = {1'b0, req_addr};
  assign addr_in_range = (addr_ext < DEPTH_LIM);
  assign addr_in_ram   = addr_in_range && (addr_ext >= ROM_LIM);
  assign accept        = req_valid && (state_q == ST_RUN);
  assign wr_ok         = mode && addr_in_ram;
  // When ROM_WORDS == DEPTH the counter starts past the last word, so the
  // CLEAR state exits after a single cycle without writing.
  assign clr_last      = (clr_addr_q >= LAST_ADDR);

  // Array port mux: the clear sequencer owns the port while in CLEAR.
  always_comb begin
    arr_en    = 1'b0;
    arr_we    = 1'b0;
    arr_addr  = req_addr;
    arr_wdata = req_wdata;
    if (state_q == ST_CLEAR) begin
      arr_en    = HAS_RAM;
      arr_we    = 1'b1;
      arr_addr  = clr_addr_q[ADDR_W-1:0];
      arr_wdata = '0;
    end else if (accept) begin
      arr_we = req_we;
      arr_en = req_we ? wr_ok : addr_in_range;
    end
  end

  // Next state: clr_req is only honoured in RUN; CLEAR runs to completion.
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    case (state_q)
      ST_RUN: begin
        if (clr_req) begin
          state_d    = ST_CLEAR;
          clr_addr_d = ROM_LIM;
        end
      end
      ST_CLEAR: begin
        if (clr_last) begin
          state_d = ST_RUN;
        end else begin
          clr_addr_d = clr_addr_q + 1'b1;
        end
      end
      default: begin
        state_d    = ST_RUN;
        clr_addr_d = ROM_LIM;
      end
    endcase
    busy_d  = (state_d == ST_CLEAR);
    ready_d = (state_d == ST_RUN);
  end

  // Response pipeline: classify at acceptance, publish one edge later.
  always_comb begin
    pend_valid_d = accept;
    pend_err_d   = req_we ? !wr_ok : !addr_in_range;
    pend_rd_d    = accept && !req_we && addr_in_range;
    rsp_valid_d  = pend_valid_q;
    rsp_err_d    = pend_valid_q && pend_err_q;
    rsp_rdata_d  = pend_rd_q ? arr_rdata : '0;
  end

  // State, sequencer and response registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= RST_STATE;
      clr_addr_q   <= ROM_LIM;
      busy_q       <= CLR_RST;
      ready_q      <= !CLR_RST;
      pend_valid_q <= 1'b0;
      pend_err_q   <= 1'b0;
      pend_rd_q    <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_err_q    <= 1'b0;
      rsp_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      clr_addr_q   <= clr_addr_d;
      busy_q       <= busy_d;
      ready_q      <= ready_d;
      pend_valid_q <= pend_valid_d;
      pend_err_q   <= pend_err_d;
      pend_rd_q    <= pend_rd_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_err_q    <= rsp_err_d;
      rsp_rdata_q  <= rsp_rdata_d;
    end
  end

  param_mem_array #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .DEPTH    (DEPTH),
    .ROM_WORDS(ROM_WORDS)
  ) u_array (
    .clk  (clk),
    .en   (arr_en),
    .we   (arr_we),
    .addr (arr_addr),
    .wdata(arr_wdata),
    .rdata(arr_rdata)
  );

  assign req_ready = ready_q;
  assign busy      = busy_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: doc/param_mem_ctrl.md
# param_mem_ctrl

Parametrised single-port memory controller: a `DEPTH`×`DATA_W` array whose lower `ROM_WORDS` locations are a write-protected ROM image and whose upper locations are RAM. Sits behind a valid/ready request port with a one-cycle registered response and per-access error flag. A clear sequencer zeroes the RAM region one word per cycle, without touching the ROM image. It is the general successor of the team's fixed 16×8 ROM/RAM block, used wherever a small boot table plus scratch store is needed.

## Interface
Parameters:
- `DATA_W`, 8, data width in bits (≥ 4).
- `ADDR_W`, 4, address width.
- `DEPTH`, 2**`ADDR_W`, number of implemented words (≤ 2**`ADDR_W`).
- `ROM_WORDS`, 8, number of protected words at addresses 0..`ROM_WORDS`-1 (0..`DEPTH`).
- `CLEAR_ON_RESET`, 1, when 1 the clear sequence runs automatically after reset release.

Ports (reset reset, asynchronous, active-high; clock clk):
- `clk`  in  1  clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `mode`  in  1  0 = ROM-only (all writes rejected), 1 = RAM writes permitted.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  controller can accept a request.
- `req_we`  in  1  1 = write, 0 = read.
- `req_addr`  in  `ADDR_W`  word address.
- `req_wdata`  in  `DATA_W`  write data.
- `rsp_valid`  out  1  one-cycle response strobe.
- `rsp_rdata`  out  `DATA_W`  read data.
- `rsp_err`  out  1  access rejected.
- `clr_req`  in  1  start RAM-region clear (level sampled per cycle).
- `busy`  out  1  clear sequence in progress.

## Operation
- Power-up contents: word i = ((i+1)·0x11) truncated to `DATA_W` for i < `ROM_WORDS`; all other words 0. Reset does not alter the array.
- FSM states: RUN and CLEAR.
  - Reset enters CLEAR if `CLEAR_ON_RESET`=1, else RUN.
  - RUN → CLEAR when `clr_req`=1.
  - CLEAR → RUN after writing the last word (`DEPTH`-1).
- `req_ready` = (state == RUN); `busy` = (state == CLEAR).
- CLEAR writes 0 to addresses `ROM_WORDS`..`DEPTH`-1, one per cycle, in ascending order. If `ROM_WORDS` = `DEPTH`, CLEAR lasts exactly one cycle with no writes.
- A request is accepted on a rising edge with `req_valid` & `req_ready`. `mode` is sampled at acceptance.
- Read, `req_addr` < `DEPTH`: `rsp_rdata` = word, `rsp_err` = 0.
- Read, `req_addr` ≥ `DEPTH`: `rsp_rdata` = 0, `rsp_err` = 1.
- Write succeeds only if `mode`=1, `ROM_WORDS` ≤ `req_addr` < `DEPTH`. Otherwise the array is unchanged and `rsp_err` = 1. Every write response has `rsp_rdata` = 0.
- `clr_req` in CLEAR is ignored; it does not restart the sequence.
- `clr_req` together with an accepted request in RUN: the request completes normally, and CLEAR begins the next cycle.

## Timing
- Reset values: `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, `busy`=`CLEAR_ON_RESET`, `req_ready`=!`CLEAR_ON_RESET`. Clear address counter = `ROM_WORDS`.
- Response latency is exactly 1 cycle: a request accepted at edge N gives `rsp_valid`=1 after edge N+1, for one cycle. Back-to-back requests give back-to-back responses at full throughput.
- Read-after-write to the same address on consecutive cycles returns the new data (write at edge N, read accepted at N+1 returns it at N+2).
- CLEAR duration: `DEPTH`-`ROM_WORDS` cycles (min 1). `req_ready` rises the cycle after the final clear write.
- Reset asserted mid-CLEAR or mid-response: outputs go to reset values immediately. A partial clear leaves its already-zeroed words zero. Any pending response is discarded.

## Structure
- Package `param_mem_pkg`: FSM state enum (`ST_RUN`, `ST_CLEAR`) and the ROM-image function `rom_word(i, DATA_W)`.
- Sub-module `param_mem_array`: single-port synchronous array with registered read, write enable and initial-content generation. The controller holds the FSM, address checks, clear counter and response register.

## Test plan
- Defaults, `CLEAR_ON_RESET`=1: reset release → `busy`=1 for 8 cycles, `req_ready`=0. Then read addr 3 → `rsp_rdata`=0x44, `rsp_err`=0, one cycle after acceptance.
- `mode`=1, write 0xA5 to addr 9, read addr 9 next cycle → 0xA5. Write 0xFF to addr 2 → `rsp_err`=1, and a later read of addr 2 = 0x33.
- `mode`=0, write 0x5A to addr 12 → `rsp_err`=1, addr 12 unchanged.
- `DEPTH`=12: read addr 14 → `rsp_rdata`=0, `rsp_err`=1. Write addr 13 → `rsp_err`=1.
- Fill addrs 8..15 with 0xC3, pulse `clr_req` with a read of addr 0 on the same edge. The read returns 0x11, then 8 busy cycles, then addrs 8..15 read 0 and addrs 0..7 are intact.
- Assert reset on the 4th clear cycle: outputs go to reset values, the sequence restarts, and all RAM words end at 0.
